// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: bus widths and the basic word type.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef logic [31:0] word_t;

endpackage : mips_pkg

// File: rtl/data_memory_addr_check.sv
// Data memory address decode: turns a byte address into a word index and
// flags faulting accesses when DATAMEM_BOUNDS_CHECK_EN is defined.
// Without the macro, the upper address bits and the low two bits are ignored,
// so addresses wrap modulo DEPTH*4 bytes and no fault is ever reported.
module data_memory_addr_check #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]        Address,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  output logic [$clog2(DEPTH)-1:0] wordIndex_c,
  output logic                     addrError_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Word index sits just above the byte offset.
  assign wordIndex_c = Address[2 +: IDX_W];

`ifdef DATAMEM_BOUNDS_CHECK_EN
  logic misaligned;
  logic outOfRange;

  // Only enabled accesses can fault: misaligned, or beyond the last word.
  assign misaligned  = |Address[1:0];
  assign outOfRange  = Address[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);
  assign addrError_c = (MemRead | MemWrite) & (misaligned | outOfRange);
`else
  logic unusedBits;

  // Address bits outside the index and the enables do not matter here.
  assign unusedBits  = ^{Address, MemRead, MemWrite};
  assign addrError_c = 1'b0;
`endif

endmodule : data_memory_addr_check

// File: rtl/data_memory.sv
// MEM-stage word-organised data memory for the single-cycle MIPS datapath.
// Full-word writes on the rising edge, combinational reads, synchronous
// active-high reset that clears the whole array.
// Optional macro: DATAMEM_BOUNDS_CHECK_EN (fault flag, suppresses faulting
// writes and zeroes faulting reads).
module data_memory #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ReadData,
  output logic              AddrError
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wordIndex;
  logic              addrError;
  logic              writeEn;

  data_memory_addr_check #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .Address     (Address),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .wordIndex_c (wordIndex),
    .addrError_c (addrError)
  );

  assign writeEn = MemWrite & ~addrError;

  // Storage update: reset clears every word and beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEn) begin
      mem[wordIndex] <= WriteData;
    end
  end

  // Combinational read; disabled or faulting reads return zero.
  assign ReadData  = (MemRead && !addrError) ? mem[wordIndex] : '0;
  assign AddrError = addrError;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected responses,
// a monitor compares them against the DUT on the falling clock edge.
module tb_data_memory;
  import mips_pkg::*;

  typedef struct {
    string name;
    word_t rd;
    logic  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  word_t       WriteData;
  logic        MemRead;
  logic        MemWrite;
  word_t       ReadData;
  logic        AddrError;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  data_memory #(
    .DEPTH  (256),
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .AddrError (AddrError)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: drive just after the rising edge, queue the
  // response expected before the next rising edge.
  task automatic cyc(input logic r, input logic [31:0] a, input word_t wd,
                     input logic rdE, input logic wrE,
                     input word_t expRd, input logic expErr, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    Address   = a;
    WriteData = wd;
    MemRead   = rdE;
    MemWrite  = wrE;
    e.name = nm;
    e.rd   = expRd;
    e.err  = expErr;
    expQ.push_back(e);
  endtask

  // Monitor: compare everything queued against the settled DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nChecks++;
        if (ReadData !== e.rd) begin
          nFails++;
          $display("FAIL %s ReadData actual=%h required=%h", e.name, ReadData, e.rd);
        end
        nChecks++;
        if (AddrError !== e.err) begin
          nFails++;
          $display("FAIL %s AddrError actual=%b required=%b", e.name, AddrError, e.err);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    Address   = '0;
    WriteData = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;

    cyc(1, 32'd0, 32'h0, 0, 0, 32'h0, 0, "reset_rd_off");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'h0, 0, "reset_state");
    cyc(0, 32'd0, 32'hDEADBEEF, 0, 1, 32'h0, 0, "wr0");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'hDEADBEEF, 0, "rd0");
    cyc(0, 32'd0, 32'h0, 0, 0, 32'h0, 0, "rd0_disabled");
    cyc(0, 32'd4, 32'h11111111, 0, 1, 32'h0, 0, "wr4");
    cyc(0, 32'd8, 32'h22222222, 0, 1, 32'h0, 0, "wr8");
    cyc(0, 32'd4, 32'h0, 1, 0, 32'h11111111, 0, "rd4");
    cyc(0, 32'd8, 32'h0, 1, 0, 32'h22222222, 0, "rd8");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'hDEADBEEF, 0, "rd0_kept");
    // Reset is synchronous: contents still visible until the edge.
    cyc(1, 32'd4, 32'hFFFFFFFF, 1, 1, 32'h11111111, 0, "reset_with_wr");
    cyc(0, 32'd4, 32'h0, 1, 0, 32'h0, 0, "rd4_cleared");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'h0, 0, "rd0_cleared");
    cyc(0, 32'd8, 32'h0, 1, 0, 32'h0, 0, "rd8_cleared");
    cyc(0, 32'd12, 32'hA, 0, 1, 32'h0, 0, "wr12_old");
    cyc(0, 32'd12, 32'hB, 1, 1, 32'hA, 0, "rdwr12_before");
    cyc(0, 32'd12, 32'h0, 1, 0, 32'hB, 0, "rdwr12_after");
    cyc(0, 32'd1020, 32'h77, 0, 1, 32'h0, 0, "wr_top");
    cyc(0, 32'd1020, 32'h0, 1, 0, 32'h77, 0, "rd_top");
`ifdef DATAMEM_BOUNDS_CHECK_EN
    cyc(0, 32'd15, 32'h0, 1, 0, 32'h0, 1, "rd_misaligned");
    cyc(0, 32'd1024, 32'h5, 1, 1, 32'h0, 1, "wr_oob");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'h0, 0, "rd0_no_alias");
    cyc(0, 32'd1024, 32'h0, 1, 0, 32'h0, 1, "rd_oob");
    cyc(0, 32'd2, 32'h0, 1, 0, 32'h0, 1, "rd_addr2");
    cyc(0, 32'd2, 32'h9, 0, 1, 32'h0, 1, "wr_addr2");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'h0, 0, "rd0_after_bad_wr");
`else
    cyc(0, 32'd15, 32'h0, 1, 0, 32'hB, 0, "rd_low_bits_ignored");
    cyc(0, 32'd1024, 32'h5, 1, 1, 32'h0, 0, "wr_alias");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'h5, 0, "rd0_alias");
    cyc(0, 32'd1024, 32'h0, 1, 0, 32'h5, 0, "rd_wrap");
    cyc(0, 32'd2, 32'h0, 1, 0, 32'h5, 0, "rd_addr2");
    cyc(0, 32'd2, 32'h9, 0, 1, 32'h0, 0, "wr_addr2");
    cyc(0, 32'd0, 32'h0, 1, 0, 32'h9, 0, "rd0_after_wr2");
`endif
    cyc(0, 32'd2, 32'h0, 0, 0, 32'h0, 0, "idle_no_fault");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_data_memory

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the single-cycle MIPS datapath, sitting in the MEM stage between the ALU result (address) and the register-file write-back mux. It accepts a byte address, stores 32-bit words on the clock edge when `MemWrite` is asserted, and returns the addressed word combinationally when `MemRead` is asserted. A synchronous reset clears the whole array.

## Interface

- `DEPTH`, default 256: number of 32-bit words; power of two, at least 4.
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 32: byte-address width.
- `clk  input  1`: single clock; all state updates on its rising edge.
- `reset  input  1`: synchronous, active-high; clears every word at the clock edge.
- `Address  input  ADDR_W`: byte address.
- `WriteData  input  DATA_W`: word to store.
- `MemRead  input  1`: read enable.
- `MemWrite  input  1`: write enable.
- `ReadData  output  DATA_W`: addressed word when `MemRead`=1, else 0.
- `AddrError  output  1`: access fault flag; active only with `DATAMEM_BOUNDS_CHECK_EN`, otherwise tied 0.

## Operation

- Word index is `Address[2 +: log2(DEPTH)]`. `Address[1:0]` is ignored for indexing.
- Write: at rising `clk` with `reset`=0 and `MemWrite`=1, `mem[index] <= WriteData`. Writes are full-word only; there are no byte enables.
- Read: `ReadData` is driven combinationally. It equals `mem[index]` when `MemRead`=1 and 0 when `MemRead`=0.
- `MemRead` and `MemWrite` both 1 to the same index: `ReadData` shows the old word until the edge and the new word immediately after it.
- Reset: at rising `clk` with `reset`=1, all words become 0 and any write in that cycle is discarded. Reset wins over `MemWrite`.
- Reset mid-operation: array contents are lost. `ReadData` follows the cleared array immediately after the reset edge.
- Contents before the first reset are undefined (X in simulation).

## Timing

- Read latency: 0 cycles (combinational from `Address`/`MemRead`).
- Write latency: 1 edge. The value is visible on `ReadData` after the edge, within the same delta.
- No handshake; every enabled access completes in one cycle.
- Reset values: all words 0; `ReadData` = 0; `AddrError` = 0.

## Configuration

- `DATAMEM_BOUNDS_CHECK_EN` defined:
  - `AddrError` is combinational and equals (`MemRead` | `MemWrite`) & (`Address[1:0]` != 0 | `Address[ADDR_W-1:2]` >= `DEPTH`).
  - A faulting write is suppressed.
  - A faulting read returns 0.
- `DATAMEM_BOUNDS_CHECK_EN` undefined:
  - `AddrError` is constant 0.
  - Upper address bits are ignored, so the address wraps modulo `DEPTH*4` bytes.
  - Low two bits are ignored.

## Structure

- Shared package `mips_pkg`:
  - Constants `DATA_W`=32 and `ADDR_W`=32.
  - Typedef `word_t` (`logic [31:0]`).
- One sub-module, `data_memory_addr_check`, covers index extraction and fault detection. It is instantiated once; the bounds-check logic lives only inside it, under the macro.
- The storage array and read/write logic stay in `data_memory`.

## Test plan

- Reset, then `MemWrite`=1, `Address`=0, `WriteData`=32'hDEADBEEF for one edge. Then `MemWrite`=0, `MemRead`=1 -> `ReadData`=32'hDEADBEEF.
- Same address with `MemRead`=0 -> `ReadData`=0.
- Write 32'h11111111 to address 4 and 32'h22222222 to address 8. Read 4 -> 32'h11111111; read 8 -> 32'h22222222; read 0 -> unchanged.
- Assert `reset` for one edge together with `MemWrite`=1 (address 4, data 32'hFFFFFFFF) -> every address reads 0, including address 4.
- `MemRead`=`MemWrite`=1 at address 12 with an old value of 32'hA, writing 32'hB -> `ReadData`=32'hA before the edge and 32'hB after it.
- Address 1024 (`DEPTH`=256):
  - Macro off: write 32'h5 aliases address 0, so address 0 reads 32'h5; `AddrError`=0.
  - Macro on: `AddrError`=1, write suppressed, read returns 0.
  - Macro on, address 2: `AddrError`=1.
